alu_ctrl_stage: RTL
===================

// Module: alu_ctrl_stage
// PURPOSE
//  Registered EX-stage ALU control decoder with valid/ready handshake, flush, and a
//  multi-cycle sequencer for MUL/DIV. Decodes {opcode,funct} into ALU operation and memory
//  controls, holds them stable until the EX datapath accepts, and stalls the issue side
//  while a long-latency operation is in flight. Sits between the ID/EX register and EX.
// PARAMETERS
//  OPC_W      4  opcode width
//  FUNCT_W    6  funct width (R-type, opcode 4'h2)
//  OP_W       5  ALU operation code width
//  MUL_CYCLES 4  accept-to-out_valid latency of MUL (>=1)
//  DIV_CYCLES 8  accept-to-out_valid latency of DIV (>=1)
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  flush       in   1        synchronous squash of held/in-flight op
//  in_valid    in   1        opcode/funct valid
//  in_ready    out  1        stage can accept this cycle
//  opcode      in   OPC_W    instruction opcode
//  funct       in   FUNCT_W  R-type function field
//  out_valid   out  1        decoded control valid
//  out_ready   in   1        EX consumes control this cycle
//  operation   out  OP_W     ALU operation code
//  mem_read    out  1        load from data memory
//  mem_write   out  1        store to data memory
//  mem_to_reg  out  1        writeback selects memory data
//  illegal     out  1        undecodable opcode/funct (qualified by out_valid)
//  busy        out  1        multi-cycle op in flight
// BEHAVIOUR
//  Decode: opc B->op 1; 4->3; 5->4; 7->5; 3->2; opc 2 by funct: 20->3, 24->5, 25->2, 14->4,
//   08->B, 21->3 +mem_read+mem_to_reg, 27->A, 2A->8, 2B->9, 00->6, 02->7, 13->3 +mem_write,
//   18->C (MUL, multi), 1A->D (DIV, multi). Any other opc/funct: op 0, mem ctrls 0, illegal=1.
//   Decode is total; no latched leftovers.
//  States: IDLE, MULTI, FULL. Accept = in_valid & in_ready; payload registered on accept.
//  in_ready: IDLE=1; MULTI=0; FULL=out_ready; forced 0 while flush=1.
//  IDLE: accept single-cycle op (or multi with LAT=1) -> FULL (latency 1);
//   accept MUL/DIV with LAT>=2 -> MULTI, cnt<=LAT-1.
//  MULTI: cnt<=cnt-1 each cycle; at cnt==1 -> FULL. out_valid first high LAT cycles after
//   accept cycle. cnt width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
//  FULL: out_valid=1; all outputs stable until out_ready. out_ready&accept -> same rules as
//   IDLE (back-to-back, no bubble); out_ready&!in_valid -> IDLE.
//  mem_read/mem_write/mem_to_reg/illegal = registered value & out_valid (0 when not valid).
//  busy = (state==MULTI).
//  flush: highest priority; next state IDLE, payload and cnt cleared, in-flight MUL/DIV
//   cancelled, input in the flush cycle dropped. flush & out_ready in FULL: op not accepted.
//  Reset (rst_n low, async): state IDLE, cnt 0, operation 0, all 1-bit outputs 0 except
//   in_ready=1 after release. Reset mid-MULTI drops the op; no output pulse.
// TESTING
//  Reset, then opc 2/funct 20, out_ready=1 -> next cycle out_valid=1, operation=3, others 0.
//  opc 2/funct 21 then funct 13 back-to-back -> op 3 with mem_read=mem_to_reg=1, then op 3 with mem_write=1; no bubble.
//  opc 2/funct 18 (MUL_CYCLES=4) -> busy 3 cycles, in_ready=0, out_valid in 4th cycle, op=C.
//  FULL with op 5 and out_ready=0 for 3 cycles -> op/out_valid held; in_ready=0 until out_ready.
//  flush during DIV count -> next cycle IDLE, busy=0, out_valid never rises for that DIV.
//  opc 9 and opc 2/funct 3F -> out_valid=1, illegal=1, operation=0, mem ctrls 0.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// EX-stage ALU control decoder: registered {opcode,funct} decode with valid/ready handshake,
// synchronous flush and a countdown sequencer that stalls issue while MUL/DIV is in flight.
module alu_ctrl_stage #(
    parameter int OPC_W      = 4,
    parameter int FUNCT_W    = 6,
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    operation,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               illegal,
    output logic               busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

    localparam logic [OPC_W-1:0] OPC_RTYPE = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OPC_3     = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OPC_4     = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OPC_5     = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OPC_7     = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OPC_B     = OPC_W'(4'hB);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Upstream: in_valid & in_ready registers the decode. Downstream: out_valid & out_ready
    // retires it; until then every output is held.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic              mtr_q, mtr_d;
    logic              ill_q, ill_d;

    logic [OP_W-1:0]   dec_op;
    logic              dec_mr, dec_mw, dec_mtr, dec_ill, dec_multi;
    logic [CNT_W-1:0]  dec_lat;
    logic              accept;

    always_comb begin
        dec_op    = '0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_mtr   = 1'b0;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_lat   = '0;
        case (opcode)
            OPC_B: dec_op = OP_W'(5'h01);
            OPC_4: dec_op = OP_W'(5'h03);
            OPC_5: dec_op = OP_W'(5'h04);
            OPC_7: dec_op = OP_W'(5'h05);
            OPC_3: dec_op = OP_W'(5'h02);
            OPC_RTYPE: begin
                case (funct)
                    FUNCT_W'(6'h20): dec_op = OP_W'(5'h03);
                    FUNCT_W'(6'h24): dec_op = OP_W'(5'h05);
                    FUNCT_W'(6'h25): dec_op = OP_W'(5'h02);
                    FUNCT_W'(6'h14): dec_op = OP_W'(5'h04);
                    FUNCT_W'(6'h08): dec_op = OP_W'(5'h0B);
                    FUNCT_W'(6'h21): begin
                        dec_op  = OP_W'(5'h03);
                        dec_mr  = 1'b1;
                        dec_mtr = 1'b1;
                    end
                    FUNCT_W'(6'h27): dec_op = OP_W'(5'h0A);
                    FUNCT_W'(6'h2A): dec_op = OP_W'(5'h08);
                    FUNCT_W'(6'h2B): dec_op = OP_W'(5'h09);
                    FUNCT_W'(6'h00): dec_op = OP_W'(5'h06);
                    FUNCT_W'(6'h02): dec_op = OP_W'(5'h07);
                    FUNCT_W'(6'h13): begin
                        dec_op = OP_W'(5'h03);
                        dec_mw = 1'b1;
                    end
                    FUNCT_W'(6'h18): begin
                        dec_op    = OP_W'(5'h0C);
                        dec_multi = 1'b1;
                        dec_lat   = MUL_LAT;
                    end
                    FUNCT_W'(6'h1A): begin
                        dec_op    = OP_W'(5'h0D);
                        dec_multi = 1'b1;
                        dec_lat   = DIV_LAT;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Gated by rst_n so nothing is offered upstream while reset is asserted.
    assign in_ready = rst_n && !flush && ((state == S_IDLE) || ((state == S_FULL) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        mtr_d   = mtr_q;
        ill_d   = ill_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            op_d    = '0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            mtr_d   = 1'b0;
            ill_d   = 1'b0;
        end else begin
            case (state)
                S_MULTI: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_d = S_FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                S_FULL: begin
                    if (out_ready && !in_valid) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
            // Accept is only possible from IDLE or a retiring FULL, so it overrides the above.
            if (accept) begin
                op_d  = dec_op;
                mr_d  = dec_mr;
                mw_d  = dec_mw;
                mtr_d = dec_mtr;
                ill_d = dec_ill;
                if (dec_multi && (dec_lat > CNT_W'(1))) begin
                    state_d = S_MULTI;
                    cnt_d   = dec_lat - CNT_W'(1);
                end else begin
                    state_d = S_FULL;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            mr_q  <= 1'b0;
            mw_q  <= 1'b0;
            mtr_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            op_q  <= op_d;
            mr_q  <= mr_d;
            mw_q  <= mw_d;
            mtr_q <= mtr_d;
            ill_q <= ill_d;
        end
    end

    assign out_valid  = (state == S_FULL);
    assign busy       = (state == S_MULTI);
    assign operation  = op_q;
    assign mem_read   = mr_q  && out_valid;
    assign mem_write  = mw_q  && out_valid;
    assign mem_to_reg = mtr_q && out_valid;
    assign illegal    = ill_q && out_valid;

endmodule
